upload_arbiter: RTL and testbench
=================================

UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 Parameter: NUM_SRC, default 3, number of upload requesters (I2C, UART, SPI handlers and similar).
REQ-002 Parameter: HDR0, default 8'hAA, first frame header byte.
REQ-003 Parameter: HDR1, default 8'h44, second frame header byte.
REQ-004 Port: clk  input  1  sole clock; all logic is rising-edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: src_req  input  NUM_SRC  source i has a packet pending.
REQ-007 Port: src_cmd  input  NUM_SRC*8  per-source command/type byte, slice i = [8i+7:8i].
REQ-008 Port: src_len  input  NUM_SRC*16  per-source payload length in bytes.
REQ-009 Port: src_data  input  NUM_SRC*8  per-source payload byte.
REQ-010 Port: src_valid  input  NUM_SRC  per-source payload byte valid.
REQ-011 Port: src_ready  output  NUM_SRC  payload byte accepted from source i.
REQ-012 Port: src_grant  output  NUM_SRC  one-hot grant, held for the whole frame.
REQ-013 Port: upload_data  output  8  framed byte to the USB upload path.
REQ-014 Port: upload_valid  output  1  upload_data valid.
REQ-015 Port: upload_ready  input  1  sink accepts the byte; a transfer is upload_valid && upload_ready.
REQ-016 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Frame format SHALL be: HDR0, HDR1, cmd, len[15:8], len[7:0], payload[len], checksum.
REQ-018 Checksum SHALL be the 8-bit modulo-256 sum of cmd, len[15:8], len[7:0] and all payload bytes.
REQ-019 FSM states SHALL be IDLE, H0, H1, CMD, LENH, LENL, DATA, CSUM.
REQ-020 IDLE with any src_req high: the next edge latches the winner's cmd/len, sets src_grant, and enters H0 with upload_valid=1 in that cycle.
REQ-021 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_SRC; after reset, source 0 has highest priority.
REQ-022 H0 through LENL and CSUM SHALL drive upload_valid=1, advance only on a transfer, and hold upload_data stable while stalled.
REQ-023 LENL on transfer: go to CSUM if the latched len==0, else go to DATA.
REQ-024 In DATA, upload_valid = src_valid[g], upload_data = src_data[g], and src_ready[g] = upload_ready; all other src_ready bits = 0.
REQ-025 DATA SHALL count transfers with a 16-bit counter and leave for CSUM after exactly len transfers.
REQ-026 CSUM on transfer: clear src_grant, update last_grant, and return to IDLE, giving at least one idle cycle between frames.
REQ-027 src_req/src_cmd/src_len changes after grant SHALL be ignored until the frame ends; src_valid of non-granted sources SHALL be ignored.
REQ-028 Outside DATA, src_ready SHALL be all zero.

Reset
REQ-029 On rst, asynchronously: state=IDLE, src_grant=0, src_ready=0, upload_valid=0, upload_data=0, busy=0, counter=0, checksum=0, last_grant=NUM_SRC-1.
REQ-030 Reset mid-frame SHALL truncate the frame without emitting further bytes; the next frame SHALL start from H0.

Verification
REQ-031 src1 req, cmd 06, len 1, data DE, upload_ready=1 -> bytes AA 44 06 00 01 DE E5; grant=3'b010 throughout.
REQ-032 All three req together after reset, then src0 and src2 re-request after frame 1 -> grant order 0, 1, 2, 0.
REQ-033 src0 cmd 04, len 0 -> AA 44 04 00 00 04; src_ready never asserted.
REQ-034 cmd 05, len 4, data DE AD BE EF, upload_ready toggling each cycle -> AA 44 05 00 04 DE AD BE EF 41, with no byte dropped or duplicated.
REQ-035 src_valid low for 3 cycles mid-payload -> upload_valid low for those 3 cycles; frame and checksum unchanged.
REQ-036 rst pulsed in DATA -> all outputs 0 immediately; next request from src2 with src0 also requesting -> src0 granted first.

Source files
------------

// File: rtl/upload_arbiter.sv
// rtl/upload_arbiter.sv - round-robin framer merging source packets onto the USB upload byte stream
// Frame: HDR0 HDR1 cmd lenH lenL payload[len] checksum.
module upload_arbiter #(
  parameter int         NUM_SRC = 3,
  parameter logic [7:0] HDR0    = 8'hAA,
  parameter logic [7:0] HDR1    = 8'h44
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_req,
  input  logic [NUM_SRC*8-1:0]    src_cmd,
  input  logic [NUM_SRC*16-1:0]   src_len,
  input  logic [NUM_SRC*8-1:0]    src_data,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [NUM_SRC-1:0]      src_grant,
  output logic [7:0]              upload_data,
  output logic                    upload_valid,
  input  logic                    upload_ready,
  output logic                    busy
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {IDLE, H0, H1, CMD, LENH, LENL, DATA, CSUM} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt_idx, last_grant, win_idx, cand;
  logic          win_found;
  logic [7:0]    cmd_q, csum, win_cmd, gnt_data;
  logic [15:0]   len_q, cnt, win_len;
  logic          gnt_valid, xfer;
  int            idx;

  assign xfer      = upload_valid && upload_ready;
  assign win_cmd   = src_cmd[{win_idx, 3'b000} +: 8];
  assign win_len   = src_len[{win_idx, 4'b0000} +: 16];
  assign gnt_data  = src_data[{gnt_idx, 3'b000} +: 8];
  assign gnt_valid = src_valid[gnt_idx];

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = IW'(idx);
      if (!win_found && src_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = H0;
      H0:      if (xfer) state_nxt = H1;
      H1:      if (xfer) state_nxt = CMD;
      CMD:     if (xfer) state_nxt = LENH;
      LENH:    if (xfer) state_nxt = LENL;
      LENL:    if (xfer) state_nxt = (len_q == 16'd0) ? CSUM : DATA;
      DATA:    if (xfer && (cnt == len_q - 16'd1)) state_nxt = CSUM;
      CSUM:    if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upload_data  = 8'h00;
    upload_valid = 1'b0;
    src_ready    = '0;
    src_grant    = '0;
    busy         = (state != IDLE);
    if (state != IDLE) src_grant[gnt_idx] = 1'b1;
    case (state)
      H0:   begin upload_data = HDR0;         upload_valid = 1'b1; end
      H1:   begin upload_data = HDR1;         upload_valid = 1'b1; end
      CMD:  begin upload_data = cmd_q;        upload_valid = 1'b1; end
      LENH: begin upload_data = len_q[15:8];  upload_valid = 1'b1; end
      LENL: begin upload_data = len_q[7:0];   upload_valid = 1'b1; end
      DATA: begin
        upload_data        = gnt_data;
        upload_valid       = gnt_valid;
        src_ready[gnt_idx] = upload_ready;
      end
      CSUM: begin upload_data = csum;         upload_valid = 1'b1; end
      default: ;
    endcase
  end

  // Header fields are folded into the checksum at grant time; payload adds on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx    <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      cmd_q      <= 8'h00;
      len_q      <= 16'h0000;
      cnt        <= 16'h0000;
      csum       <= 8'h00;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          gnt_idx <= win_idx;
          cmd_q   <= win_cmd;
          len_q   <= win_len;
          cnt     <= 16'h0000;
          csum    <= win_cmd + win_len[15:8] + win_len[7:0];
        end
        DATA: if (xfer) begin
          cnt  <= cnt + 16'd1;
          csum <= csum + gnt_data;
        end
        CSUM: if (xfer) last_grant <= gnt_idx;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_upload_arbiter.sv
// tb/tb_upload_arbiter.sv - directed self-checking bench for upload_arbiter
module tb_upload_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_req, src_valid, src_ready, src_grant;
  logic [23:0] src_cmd, src_data;
  logic [47:0] src_len;
  logic [7:0]  upload_data;
  logic        upload_valid, upload_ready, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] pay [0:15];
  int pay_len, psrc, ptr, gap_at, gap_left;
  bit toggle_rdy;
  logic [7:0] got [0:31];
  int got_n, grant_bad, ready_cnt, low_cnt;
  bit timed_out;

  upload_arbiter dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_cmd(src_cmd), .src_len(src_len),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_grant(src_grant), .upload_data(upload_data),
    .upload_valid(upload_valid), .upload_ready(upload_ready), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic set_src(input int s, input logic [7:0] cmd, input logic [15:0] len);
    src_cmd[8*s +: 8]  = cmd;
    src_len[16*s +: 16] = len;
  endtask

  task automatic drive_src();
    if (gap_left > 0 && ptr == gap_at) begin
      src_valid[psrc] = 1'b0;
      gap_left--;
    end else begin
      src_valid[psrc] = (ptr < pay_len);
      src_data[8*psrc +: 8] = (ptr < pay_len) ? pay[ptr] : 8'h00;
    end
  endtask

  // Plays source s's payload and collects nbytes upload transfers.
  task automatic run_frame(input int s, input int nbytes);
    bit consumed, done;
    ptr = 0; got_n = 0; grant_bad = 0; ready_cnt = 0; low_cnt = 0; timed_out = 1'b1;
    psrc = s;
    drive_src();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (upload_valid && upload_ready) begin
        if (got_n < 32) got[got_n] = upload_data;
        got_n++;
      end
      if (busy) begin
        if (src_grant !== (3'b001 << s)) grant_bad++;
        src_req[s] = 1'b0;
      end
      if (|src_ready) ready_cnt++;
      if (busy && !src_valid[s] && !upload_valid) low_cnt++;
      consumed = src_ready[s] && src_valid[s];
      done = (got_n >= nbytes);
      @(posedge clk); #1;
      if (consumed) ptr++;
      if (toggle_rdy) upload_ready = ~upload_ready;
      drive_src();
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    src_valid[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_req = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (src_grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", src_grant); end
    checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", src_ready); end
    checks++; if (upload_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", upload_valid); end
    checks++; if (upload_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", upload_data); end
    src_req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] e [0:6];
    e = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h01, 8'hDE, 8'hE5};
    set_src(1, 8'h06, 16'd1);
    pay[0] = 8'hDE; pay_len = 1; gap_left = 0; toggle_rdy = 1'b0; upload_ready = 1'b1;
    src_req[1] = 1'b1;
    run_frame(1, 7);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got %0d bytes expected 7", got_n); end
    checks++; if (got_n !== 7) begin errors++; $display("FAIL single_count: got %0d expected 7", got_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, got[i], e[i]); end
    end
    checks++; if (grant_bad !== 0) begin errors++; $display("FAIL single_grant: got %0d bad cycles expected 0", grant_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_zero_len();
    logic [7:0] e [0:5];
    e = '{8'hAA, 8'h44, 8'h04, 8'h00, 8'h00, 8'h04};
    set_src(0, 8'h04, 16'd0);
    pay_len = 0; gap_left = 0;
    src_req[0] = 1'b1;
    run_frame(0, 6);
    checks++; if (timed_out || got_n !== 6) begin errors++; $display("FAIL zero_count: got %0d expected 6", got_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL zero_byte%0d: got %h expected %h", i, got[i], e[i]); end
    end
    checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL zero_ready: got %0d ready cycles expected 0", ready_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [0:9];
    e = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h41};
    set_src(2, 8'h05, 16'd4);
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF; pay_len = 4; gap_left = 0;
    toggle_rdy = 1'b1;
    src_req[2] = 1'b1;
    run_frame(2, 10);
    toggle_rdy = 1'b0; upload_ready = 1'b1;
    checks++; if (timed_out || got_n !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", got_n); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], e[i]); end
    end
    checks++; if (grant_bad !== 0) begin errors++; $display("FAIL bp_grant: got %0d bad cycles expected 0", grant_bad); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_valid_gap();
    logic [7:0] e [0:9];
    e = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h41};
    set_src(1, 8'h05, 16'd4);
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF; pay_len = 4;
    gap_at = 2; gap_left = 3;
    src_req[1] = 1'b1;
    run_frame(1, 10);
    checks++; if (timed_out || got_n !== 10) begin errors++; $display("FAIL gap_count: got %0d expected 10", got_n); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== e[i]) begin errors++; $display("FAIL gap_byte%0d: got %h expected %h", i, got[i], e[i]); end
    end
    checks++; if (low_cnt !== 3) begin errors++; $display("FAIL gap_low_cycles: got %0d expected 3", low_cnt); end
    gap_left = 0;
  endtask

  task automatic test_round_robin();
    int order [0:3];
    logic [7:0] cmds [0:2];
    order = '{0, 1, 2, 0};
    cmds  = '{8'h10, 8'h11, 8'h12};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, cmds[s], 16'd0);
    pay_len = 0; gap_left = 0;
    src_req = 3'b111;
    for (int f = 0; f < 4; f++) begin
      run_frame(order[f], 6);
      checks++; if (timed_out || grant_bad !== 0) begin errors++; $display("FAIL rr_grant%0d: got %0d bad cycles expected 0 for src%0d", f, grant_bad, order[f]); end
      checks++; if (got[2] !== cmds[order[f]]) begin errors++; $display("FAIL rr_cmd%0d: got %h expected %h", f, got[2], cmds[order[f]]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got %b expected 0", f, busy); end
      if (f == 0) begin
        src_req[0] = 1'b1;
        src_req[2] = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    set_src(1, 8'h07, 16'd4);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay_len = 4;
    psrc = 1; ptr = 0; gap_left = 0;
    drive_src();
    src_req[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (src_ready[1] !== 1'b1) begin errors++; $display("FAIL mid_in_data: got ready %b expected 1", src_ready[1]); end
    #3 rst = 1'b1;
    #1;
    checks++; if (upload_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", upload_valid); end
    checks++; if (src_grant !== 3'b000) begin errors++; $display("FAIL mid_grant: got %b expected 000", src_grant); end
    checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL mid_ready: got %b expected 000", src_ready); end
    checks++; if (busy !== 1'b0 || upload_data !== 8'h00) begin errors++; $display("FAIL mid_busy_data: got %b/%h expected 0/00", busy, upload_data); end
    src_req = 3'b000; src_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    set_src(0, 8'h20, 16'd0);
    set_src(2, 8'h22, 16'd0);
    pay_len = 0;
    src_req[0] = 1'b1;
    src_req[2] = 1'b1;
    run_frame(0, 6);
    checks++; if (timed_out || grant_bad !== 0) begin errors++; $display("FAIL mid_next_grant: got %0d bad cycles expected 0 for src0", grant_bad); end
    checks++; if (got[0] !== 8'hAA || got[1] !== 8'h44) begin errors++; $display("FAIL mid_next_hdr: got %h %h expected aa 44", got[0], got[1]); end
    checks++; if (got[2] !== 8'h20 || got[5] !== 8'h20) begin errors++; $display("FAIL mid_next_cmd: got %h/%h expected 20/20", got[2], got[5]); end
    src_req = 3'b000;
  endtask

  initial begin
    src_req = '0; src_valid = '0; src_cmd = '0; src_data = '0; src_len = '0;
    upload_ready = 1'b1; toggle_rdy = 1'b0;
    pay_len = 0; psrc = 0; ptr = 0; gap_at = 0; gap_left = 0;
    test_reset();
    test_single();
    test_zero_len();
    test_backpressure();
    test_valid_gap();
    test_round_robin();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
